// File: rtl/witness_search_ctrl.sv
// Enumerates existential candidates against a combinational check netlist and reports the first witness.
// Optional WSC_SAT_COUNT_EN: sweep the whole space and count satisfying candidates in sat_count.
module witness_search_ctrl #(
  parameter int N_UNIV  = 2,
  parameter int N_EXIST = 3,
  parameter int SETTLE  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_UNIV-1:0]  univ_in,
  output logic [N_UNIV-1:0]  univ_out,
  output logic [N_EXIST-1:0] cand_out,
  input  logic               spec_ok,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [N_EXIST-1:0] witness,
`ifdef WSC_SAT_COUNT_EN
  output logic [N_EXIST:0]   sat_count,
`endif
  output logic [N_EXIST:0]   tries
);

  typedef enum logic [1:0] {IDLE, SETTLE_W, CHECK, FIN} state_t;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SET_LD = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  // With SETTLE=0 the settle state is skipped entirely.
  localparam state_t POST = (SETTLE > 0) ? SETTLE_W : CHECK;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [N_UNIV-1:0]  univ_q;
  logic [N_EXIST-1:0] cand_q, witness_q;
  logic [N_EXIST:0]   tries_q;
  logic               busy_q, done_q, found_q;
`ifdef WSC_SAT_COUNT_EN
  logic [N_EXIST:0]   sat_q;
`endif

  logic last_c;
  assign last_c = &cand_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      univ_q    <= '0;
      cand_q    <= '0;
      witness_q <= '0;
      tries_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
`ifdef WSC_SAT_COUNT_EN
      sat_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            univ_q    <= univ_in;
            cand_q    <= '0;
            tries_q   <= '0;
            found_q   <= 1'b0;
            witness_q <= '0;
`ifdef WSC_SAT_COUNT_EN
            sat_q     <= '0;
`endif
            cnt_q     <= SET_LD;
            busy_q    <= 1'b1;
            state_q   <= POST;
          end
        end
        SETTLE_W: begin
          if (cnt_q == '0) state_q <= CHECK;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        CHECK: begin
          tries_q <= tries_q + 1'b1;
`ifdef WSC_SAT_COUNT_EN
          // Full sweep: count every hit, keep only the first as witness.
          if (spec_ok) begin
            sat_q <= sat_q + 1'b1;
            if (!found_q) begin
              found_q   <= 1'b1;
              witness_q <= cand_q;
            end
          end
          if (last_c) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            cand_q  <= cand_q + 1'b1;
            cnt_q   <= SET_LD;
            state_q <= POST;
          end
`else
          if (spec_ok) begin
            found_q   <= 1'b1;
            witness_q <= cand_q;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= FIN;
          end else if (last_c) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            cand_q  <= cand_q + 1'b1;
            cnt_q   <= SET_LD;
            state_q <= POST;
          end
`endif
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign univ_out = univ_q;
  assign cand_out = cand_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign found    = found_q;
  assign witness  = witness_q;
  assign tries    = tries_q;
`ifdef WSC_SAT_COUNT_EN
  assign sat_count = sat_q;
`endif

endmodule

// File: tb/tb_witness_search_ctrl.sv
// Bench for witness_search_ctrl: SETTLE=1 and SETTLE=0 instances checked against a search-result model.
module tb_witness_search_ctrl;

`ifdef WSC_SAT_COUNT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, st1, st0;
  logic [1:0] univ_in;
  logic [7:0] m1, m0;
  logic [1:0] u1, u0;
  logic [2:0] c1, c0, w1, w0;
  logic [3:0] t1, t0, s1, s0;
  logic       b1, b0, d1, d0, f1, f0, ok1, ok0;

  // Netlist stand-in: truth table over the candidate.
  assign ok1 = m1[c1];
  assign ok0 = m0[c0];

  witness_search_ctrl #(.N_UNIV(2), .N_EXIST(3), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .univ_in(univ_in), .univ_out(u1),
    .cand_out(c1), .spec_ok(ok1), .busy(b1), .done(d1), .found(f1),
    .witness(w1),
`ifdef WSC_SAT_COUNT_EN
    .sat_count(s1),
`endif
    .tries(t1));

  witness_search_ctrl #(.N_UNIV(2), .N_EXIST(3), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(st0), .univ_in(univ_in), .univ_out(u0),
    .cand_out(c0), .spec_ok(ok0), .busy(b0), .done(d0), .found(f0),
    .witness(w0),
`ifdef WSC_SAT_COUNT_EN
    .sat_count(s0),
`endif
    .tries(t0));

`ifndef WSC_SAT_COUNT_EN
  assign s1 = '0;
  assign s0 = '0;
`endif

  int errors = 0, checks = 0;
  int sel_v = 1;

  logic [1:0] o_u; logic [2:0] o_c, o_w; logic [3:0] o_t, o_s; logic o_b, o_d, o_f;
  assign o_u = sel_v ? u1 : u0;
  assign o_c = sel_v ? c1 : c0;
  assign o_w = sel_v ? w1 : w0;
  assign o_t = sel_v ? t1 : t0;
  assign o_s = sel_v ? s1 : s0;
  assign o_b = sel_v ? b1 : b0;
  assign o_d = sel_v ? d1 : d0;
  assign o_f = sel_v ? f1 : f0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic setst(input int sel, input logic v);
    if (sel != 0) st1 = v; else st0 = v;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".univ"}, o_u, 0);  chk({tag, ".cand"}, o_c, 0);
    chk({tag, ".busy"}, o_b, 0);  chk({tag, ".done"}, o_d, 0);
    chk({tag, ".found"}, o_f, 0); chk({tag, ".wit"}, o_w, 0);
    chk({tag, ".tries"}, o_t, 0);
    if (SAT) chk({tag, ".sat"}, o_s, 0);
  endtask

  // Model: the search result follows directly from the truth table.
  task automatic run(input int sel, input logic [1:0] u, input logic [7:0] m,
                     input bit restart, input string nm);
    int s, first, tr, dl, lastc, ce;
    bit fnd;
    s = (sel != 0) ? 1 : 0;
    sel_v = sel;
    first = -1;
    for (int i = 0; i < 8; i++) if (m[i] && first < 0) first = i;
    fnd = (first >= 0);
    tr  = (SAT || !fnd) ? 8 : first + 1;
    dl  = tr * (s + 1) + 1;        // done visible at the sample after edge dl-1
    lastc = tr - 1;
    if (sel != 0) m1 = m; else m0 = m;
    univ_in = u;
    setst(sel, 1'b1);
    step();
    setst(sel, 1'b0);
    univ_in = ~u;
    for (int e = 0; e <= dl; e++) begin
      ce = e / (s + 1);
      if (ce > lastc) ce = lastc;
      chk({nm, ".busy"}, o_b, (e < dl - 1) ? 1 : 0);
      chk({nm, ".done"}, o_d, (e == dl - 1) ? 1 : 0);
      chk({nm, ".cand"}, o_c, ce);
      chk({nm, ".univ"}, o_u, u);
      if (e == dl - 1) begin
        chk({nm, ".found"}, o_f, fnd);
        chk({nm, ".wit"}, o_w, fnd ? first : 0);
        chk({nm, ".tries"}, o_t, tr);
        if (SAT) chk({nm, ".sat"}, o_s, $countones(m));
      end
      setst(sel, restart && (e + 1 == 3 || e + 1 == 13));
      step();
    end
    setst(sel, 1'b0);
    chk({nm, ".idle_busy"}, o_b, 0);
    chk({nm, ".idle_done"}, o_d, 0);
    chk({nm, ".hold_found"}, o_f, fnd);
  endtask

  initial begin
    rst = 1'b1; st1 = 1'b0; st0 = 1'b0; univ_in = '0; m1 = '0; m0 = '0;
    step(); step();
    sel_v = 1; chk_zero("rst1");
    sel_v = 0; chk_zero("rst0");
    rst = 1'b0;
    step();

    run(1, 2'b01, 8'b0010_0000, 1'b0, "t1_wit5");
    run(1, 2'b11, 8'b0000_0000, 1'b0, "t2_unsat");
    run(0, 2'b10, 8'b1111_1111, 1'b0, "t3_settle0");
    run(1, 2'b01, 8'b0010_0000, 1'b1, "t4_restart");

    // Reset in the middle of an unsat sweep.
    sel_v = 1; m1 = '0; univ_in = 2'b10;
    st1 = 1'b1; step(); st1 = 1'b0;
    for (int e = 0; e < 5; e++) step();
    rst = 1'b1;
    step();
    chk_zero("t5_rst");
    rst = 1'b0;
    for (int e = 0; e < 4; e++) begin
      step();
      chk("t5_nodone", o_d, 0);
    end
    run(1, 2'b11, 8'b0000_0000, 1'b0, "t5_after");

    run(1, 2'b00, 8'b1010_0100, 1'b0, "t6_multi");
    run(0, 2'b01, 8'b1000_0000, 1'b0, "t7_last_s0");

    for (int r = 0; r < 10; r++) begin
      logic [7:0] mr;
      logic [1:0] ur;
      mr = 8'($urandom_range(0, 255));
      if (r % 4 == 0) mr = '0;
      ur = 2'($urandom_range(0, 3));
      run(r % 2, ur, mr, 1'b0, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
